// File: rtl/shell_engine.sv
// Single tank shell: fires on a fire edge, steps across the 128x128 world,
// checks target/obstruction per cell and draws a 4x4 pixel overlay.
module shell_engine #(
    parameter int unsigned STEP_TICKS  = 1_000_000,
    parameter int unsigned MAX_STEPS   = 64,
    parameter logic [11:0] SHELL_COLOR = 12'hF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fire,
    input  logic [7:0]  shooter_x,
    input  logic [7:0]  shooter_y,
    input  logic [7:0]  shooter_info,
    input  logic [7:0]  target_x,
    input  logic [7:0]  target_y,
    input  logic        target_burst,
    output logic [6:0]  map_x,
    output logic [6:0]  map_y,
    input  logic [1:0]  map_val,
    input  logic [11:0] pixel_column,
    input  logic [11:0] pixel_row,
    output logic        hit,
    output logic        busy,
    output logic        shell_icon,
    output logic [11:0] shell_c
);

    localparam int unsigned TICK_W = $clog2(STEP_TICKS);
    localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);
    localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(STEP_TICKS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FLY, S_MOVE, S_WAIT1, S_WAIT2, S_CHECK
    } state_t;

    state_t            state;
    logic              fire_d;
    logic [1:0]        dir;
    logic [6:0]        sx;
    logic [6:0]        sy;
    logic [TICK_W-1:0] tick_cnt;
    logic [STEP_W-1:0] step_cnt;

    logic              fire_edge;
    logic              edge_out;
    logic [6:0]        next_x;
    logic [6:0]        next_y;
    logic              in_box;
    logic              on_pix;
    logic [11:0]       col_base;
    logic [11:0]       row_base;
    logic              unused_ok;

    assign fire_edge = fire & ~fire_d;
    assign unused_ok = ^{shooter_info[7:3], map_val[0]};

    // Next cell one step along the latched direction (0 N, 1 E, 2 S, 3 W)
    always_comb begin
        next_x   = sx;
        next_y   = sy;
        edge_out = 1'b0;
        case (dir)
            2'd0: if (sy == 7'd0)   edge_out = 1'b1; else next_y = sy - 7'd1;
            2'd1: if (sx == 7'd127) edge_out = 1'b1; else next_x = sx + 7'd1;
            2'd2: if (sy == 7'd127) edge_out = 1'b1; else next_y = sy + 7'd1;
            default: if (sx == 7'd0) edge_out = 1'b1; else next_x = sx - 7'd1;
        endcase
    end

    // Target box is 4 cells wide, 6 cells tall; compare in 9 bits so it never wraps
    always_comb begin
        in_box = ({2'b00, sx} >= {1'b0, target_x}) &&
                 ({2'b00, sx} <= ({1'b0, target_x} + 9'd3)) &&
                 ({2'b00, sy} >= {1'b0, target_y}) &&
                 ({2'b00, sy} <= ({1'b0, target_y} + 9'd5));
    end

    always_comb begin
        col_base = {2'b00, sx, 3'b000};
        row_base = 12'(sy) * 12'd6;
        on_pix   = (pixel_column >= col_base) && (pixel_column <= col_base + 12'd3) &&
                   (pixel_row >= row_base) && (pixel_row <= row_base + 12'd3);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            fire_d     <= 1'b0;
            dir        <= 2'd0;
            sx         <= 7'd0;
            sy         <= 7'd0;
            tick_cnt   <= '0;
            step_cnt   <= '0;
            map_x      <= 7'd0;
            map_y      <= 7'd0;
            hit        <= 1'b0;
            busy       <= 1'b0;
            shell_icon <= 1'b0;
            shell_c    <= 12'h000;
        end else begin
            fire_d     <= fire;
            hit        <= 1'b0;
            shell_icon <= busy && on_pix;
            shell_c    <= (busy && on_pix) ? SHELL_COLOR : 12'h000;
            case (state)
                S_IDLE: begin
                    // Only the four cardinal orientations (bit 0 clear) launch a shell
                    if (fire_edge && !shooter_info[0]) begin
                        dir      <= shooter_info[2:1];
                        sx       <= 7'(shooter_x + 8'd2);
                        sy       <= 7'(shooter_y + 8'd3);
                        step_cnt <= '0;
                        tick_cnt <= TICK_LOAD;
                        busy     <= 1'b1;
                        state    <= S_FLY;
                    end
                end
                S_FLY: begin
                    if (tick_cnt == '0) state <= S_MOVE;
                    else                tick_cnt <= tick_cnt - TICK_W'(1);
                end
                S_MOVE: begin
                    if (edge_out || step_cnt == STEP_LAST) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        sx       <= next_x;
                        sy       <= next_y;
                        map_x    <= next_x;
                        map_y    <= next_y;
                        step_cnt <= step_cnt + STEP_W'(1);
                        state    <= S_WAIT1;
                    end
                end
                S_WAIT1: state <= S_WAIT2;
                S_WAIT2: state <= S_CHECK;
                S_CHECK: begin
                    // A live target beats an obstruction in the same cell
                    if (in_box && !target_burst) begin
                        hit   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (map_val[1]) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tick_cnt <= TICK_LOAD;
                        state    <= S_FLY;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shell_engine.sv
// Bench for shell_engine: flight vectors with a result scoreboard, plus
// hand sequences for ignored fires, overlay and mid-flight reset.
module tb_shell_engine;

    localparam int unsigned STEP_TICKS = 4;
    localparam int unsigned MAX_STEPS  = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        fire;
    logic [7:0]  shooter_x, shooter_y, shooter_info;
    logic [7:0]  target_x, target_y;
    logic        target_burst;
    logic [6:0]  map_x, map_y;
    logic [1:0]  map_val;
    logic [11:0] pixel_column, pixel_row;
    logic        hit, busy, shell_icon;
    logic [11:0] shell_c;

    shell_engine #(
        .STEP_TICKS (STEP_TICKS),
        .MAX_STEPS  (MAX_STEPS),
        .SHELL_COLOR(12'hF00)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fire        (fire),
        .shooter_x   (shooter_x),
        .shooter_y   (shooter_y),
        .shooter_info(shooter_info),
        .target_x    (target_x),
        .target_y    (target_y),
        .target_burst(target_burst),
        .map_x       (map_x),
        .map_y       (map_y),
        .map_val     (map_val),
        .pixel_column(pixel_column),
        .pixel_row   (pixel_row),
        .hit         (hit),
        .busy        (busy),
        .shell_icon  (shell_icon),
        .shell_c     (shell_c)
    );

    always #5 clock = ~clock;

    // World map model: one wall cell, every other cell reads 2'b01; two-clock latency
    logic       wall_en_m;
    logic [6:0] wall_x_m, wall_y_m;
    logic [1:0] map_p1;
    always @(posedge clock) begin
        map_p1  <= (wall_en_m && map_x == wall_x_m && map_y == wall_y_m) ? 2'b10 : 2'b01;
        map_val <= map_p1;
    end

    typedef struct {
        logic [7:0] sx, sy, info, tx, ty;
        logic       burst, wall_en;
        logic [6:0] wx, wy;
        logic       exp_hit;
        int         exp_cycles;
    } vec_t;

    typedef struct {
        logic hit;
        int   cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Watch one flight until busy drops, then score it against the queued result
    task automatic run_flight(input string name, input int budget);
        exp_t e;
        int   busy_cnt = 0;
        int   hits = 0;
        int   busy_at_hit = 0;
        bit   done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clock);
            if (busy) busy_cnt++;
            if (hit) begin
                hits++;
                if (busy) busy_at_hit++;
            end
            if (!busy) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: busy still high after %0d cycles", name, budget);
        end
        repeat (3) begin
            @(negedge clock);
            if (hit) hits++;
        end
        e = sb.pop_front();
        check({name, "_hit"}, hits, e.hit ? 1 : 0);
        check({name, "_cycles"}, busy_cnt, e.cycles);
        check({name, "_busy_at_hit"}, busy_at_hit, 0);
    endtask

    task automatic setup(input vec_t v);
        @(negedge clock);
        fire         = 1'b0;
        shooter_x    = v.sx;
        shooter_y    = v.sy;
        shooter_info = v.info;
        target_x     = v.tx;
        target_y     = v.ty;
        target_burst = v.burst;
        wall_en_m    = v.wall_en;
        wall_x_m     = v.wx;
        wall_y_m     = v.wy;
    endtask

    vec_t vecs[18];

    initial begin
        int busy_pre;
        int hits;
        int busy_cnt;

        // Each step is STEP_TICKS+4 = 8 clocks; k moves then hit/wall = 8k, expire at MOVE = 8k+5
        vecs[0]  = '{8'd10,  8'd10, 8'h02, 8'd20,  8'd9,   1'b0, 1'b0, 7'd0,  7'd0,  1'b1, 64};
        vecs[1]  = '{8'd125, 8'd50, 8'h02, 8'd0,   8'd0,   1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 5};
        vecs[2]  = '{8'd124, 8'd50, 8'h02, 8'd0,   8'd0,   1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 13};
        vecs[3]  = '{8'd10,  8'd10, 8'h02, 8'd100, 8'd100, 1'b0, 1'b1, 7'd14, 7'd13, 1'b0, 16};
        vecs[4]  = '{8'd10,  8'd10, 8'h02, 8'd14,  8'd10,  1'b0, 1'b1, 7'd14, 7'd13, 1'b1, 16};
        vecs[5]  = '{8'd10,  8'd10, 8'h02, 8'd20,  8'd9,   1'b1, 1'b0, 7'd0,  7'd0,  1'b0, 125};
        vecs[6]  = '{8'd50,  8'd0,  8'h00, 8'd100, 8'd100, 1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 29};
        vecs[7]  = '{8'd40,  8'd40, 8'h04, 8'd41,  8'd50,  1'b0, 1'b0, 7'd0,  7'd0,  1'b1, 56};
        vecs[8]  = '{8'd5,   8'd60, 8'h06, 8'd100, 8'd100, 1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 61};
        vecs[9]  = '{8'd126, 8'd20, 8'hF6, 8'd100, 8'd100, 1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 5};
        vecs[10] = '{8'd10,  8'd10, 8'h02, 8'd20,  8'd8,   1'b0, 1'b0, 7'd0,  7'd0,  1'b1, 64};
        vecs[11] = '{8'd10,  8'd10, 8'h02, 8'd20,  8'd7,   1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 125};
        vecs[12] = '{8'd10,  8'd10, 8'h02, 8'd10,  8'd9,   1'b0, 1'b0, 7'd0,  7'd0,  1'b1, 8};
        vecs[13] = '{8'd124, 8'd50, 8'h02, 8'd126, 8'd50,  1'b0, 1'b0, 7'd0,  7'd0,  1'b1, 8};
        vecs[14] = '{8'd30,  8'd10, 8'h06, 8'd25,  8'd9,   1'b0, 1'b0, 7'd0,  7'd0,  1'b1, 32};
        vecs[15] = '{8'd10,  8'd10, 8'h12, 8'd20,  8'd9,   1'b0, 1'b0, 7'd0,  7'd0,  1'b1, 64};
        vecs[16] = '{8'd50,  8'd60, 8'h00, 8'd100, 8'd100, 1'b0, 1'b1, 7'd52, 7'd60, 1'b0, 24};
        vecs[17] = '{8'd10,  8'd10, 8'h02, 8'd14,  8'd10,  1'b1, 1'b1, 7'd14, 7'd13, 1'b0, 16};

        reset = 1'b0; fire = 1'b0;
        shooter_x = '0; shooter_y = '0; shooter_info = '0;
        target_x = '0; target_y = '0; target_burst = 1'b0;
        pixel_column = '0; pixel_row = '0;
        wall_en_m = 1'b0; wall_x_m = '0; wall_y_m = '0;

        repeat (3) @(negedge clock);
        check("rst_hit", hit, 0);
        check("rst_busy", busy, 0);
        check("rst_icon", shell_icon, 0);
        check("rst_color", shell_c, 0);
        check("rst_map_x", map_x, 0);
        check("rst_map_y", map_y, 0);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            setup(vecs[i]);
            @(negedge clock);
            fire = 1'b1;
            sb.push_back('{vecs[i].exp_hit, vecs[i].exp_cycles});
            run_flight($sformatf("vec%0d", i), 400);
        end

        // Fire edge during flight must not restart the shell
        setup(vecs[0]);
        @(negedge clock);
        fire = 1'b1;
        busy_pre = 0;
        repeat (10) begin
            @(negedge clock);
            if (busy) busy_pre++;
        end
        fire = 1'b0;
        @(negedge clock);
        if (busy) busy_pre++;
        fire = 1'b1;
        check("refire_busy_pre", busy_pre, 11);
        sb.push_back('{1'b1, 53});
        run_flight("refire", 400);

        // Holding fire high after the shell ends does not refire
        busy_cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (busy) busy_cnt++;
        end
        check("hold_fire_busy", busy_cnt, 0);

        // Diagonal orientation is dropped
        @(negedge clock);
        fire = 1'b0;
        shooter_info = 8'h01;
        @(negedge clock);
        fire = 1'b1;
        sb.push_back('{1'b0, 0});
        run_flight("orient001", 20);

        // Overlay with shell at (5,7): columns 40..43, rows 42..45
        setup('{8'd3, 8'd4, 8'h00, 8'd100, 8'd100, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 0});
        pixel_column = 12'd42;
        pixel_row    = 12'd44;
        @(negedge clock);
        fire = 1'b1;
        @(negedge clock);
        check("ovl_busy", busy, 1);
        @(negedge clock);
        check("ovl_icon_in", shell_icon, 1);
        check("ovl_color_in", shell_c, 12'hF00);
        pixel_column = 12'd44;
        @(negedge clock);
        check("ovl_icon_col44", shell_icon, 0);
        check("ovl_color_col44", shell_c, 0);
        pixel_column = 12'd43;
        pixel_row    = 12'd45;
        @(negedge clock);
        check("ovl_icon_corner", shell_icon, 1);

        // Reset while still in FLY discards the shell
        reset = 1'b0;
        fire  = 1'b0;
        @(negedge clock);
        check("midrst_busy", busy, 0);
        check("midrst_icon", shell_icon, 0);
        check("midrst_hit", hit, 0);
        reset = 1'b1;
        hits = 0;
        busy_cnt = 0;
        repeat (80) begin
            @(negedge clock);
            if (hit) hits++;
            if (busy) busy_cnt++;
        end
        check("midrst_no_hit", hits, 0);
        check("midrst_no_busy", busy_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
